// File: rtl/scandoubler.sv
// scandoubler: 15 kHz -> 31 kHz line doubler with ping-pong line buffer.
// Ports: clk_sys, reset, ce_pix, bypass, scanlines, R/G/B_in, HSync, VSync
//        -> R/G/B_out, HSync_out, VSync_out. Macro: SCANDOUBLER_SCANLINES_EN.
module scandoubler #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       bypass,
  input  logic [1:0] scanlines,
  input  logic [5:0] R_in,
  input  logic [5:0] G_in,
  input  logic [5:0] B_in,
  input  logic       HSync,
  input  logic       VSync,
  output logic [5:0] R_out,
  output logic [5:0] G_out,
  output logic [5:0] B_out,
  output logic       HSync_out,
  output logic       VSync_out
);

  localparam int AW = ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] AMAX = '1;

  typedef enum logic [1:0] {IDLE, EVEN, ODD, HOLD} state_e;

  logic          hs_q;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0] hcnt_q, hcnt_d;
  logic          sat_q, sat_d;
  logic          started_q;
  logic          wbuf_q;
  logic [AW-1:0] hs_period_q;
  logic [AW-1:0] hs_width_q;
  logic          vs_line_q;

  logic          line_edge;
  logic          line_go;
  logic [AW-1:0] period_new;
  logic          we;
  logic          wsel;
  logic [AW-1:0] waddr;

  assign line_edge = ce_pix & ~HSync & hs_q;
  // The first edge after reset closes a partial line: no valid period yet.
  assign period_new = started_q ? wcnt_q : '0;
  assign line_go = line_edge & (period_new != '0);

  // The edge pixel is pixel 0 of the new line and goes to the fresh buffer.
  assign wsel = line_edge ? ~wbuf_q : wbuf_q;
  assign waddr = line_edge ? '0 : wcnt_q;
  assign we = ce_pix & (line_edge | ~sat_q);

  always_comb begin
    wcnt_d = wcnt_q;
    hcnt_d = hcnt_q;
    sat_d = sat_q;
    if (line_edge) begin
      wcnt_d = AW'(1);
      hcnt_d = AW'(1);
      sat_d = 1'b0;
    end else if (ce_pix) begin
      if (wcnt_q != AMAX) wcnt_d = wcnt_q + AW'(1);
      else sat_d = 1'b1;
      if (!HSync && hcnt_q != AMAX) hcnt_d = hcnt_q + AW'(1);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hs_q <= 1'b0;
      wcnt_q <= '0;
      hcnt_q <= '0;
      sat_q <= 1'b0;
      started_q <= 1'b0;
      wbuf_q <= 1'b0;
      hs_period_q <= '0;
      hs_width_q <= '0;
      vs_line_q <= 1'b1;
    end else if (ce_pix) begin
      hs_q <= HSync;
      wcnt_q <= wcnt_d;
      hcnt_q <= hcnt_d;
      sat_q <= sat_d;
      if (line_edge) begin
        started_q <= 1'b1;
        hs_period_q <= period_new;
        hs_width_q <= hcnt_q;
        wbuf_q <= ~wbuf_q;
        vs_line_q <= VSync;
      end
    end
  end

  state_e      st_q;
  logic [AW:0] oc_q;
  logic [AW:0] oc_last;
  logic        act_q, odd_q, hsl_q;
  logic [17:0] rd_q;
  logic [17:0] mem_q [2*DEPTH];

  assign oc_last = {hs_period_q, 1'b0} - (AW + 1)'(1);

  always_ff @(posedge clk_sys) begin
    if (we) mem_q[{wsel, waddr}] <= {R_in, G_in, B_in};
    rd_q <= mem_q[{~wbuf_q, oc_q[AW:1]}];
  end

  logic [5:0] px_r, px_g, px_b;

`ifdef SCANDOUBLER_SCANLINES_EN
  function automatic logic [5:0] shade(
    input logic [5:0] c,
    input logic [1:0] lvl
  );
    case (lvl)
      2'd1:    return (c >> 1) + (c >> 2);
      2'd2:    return c >> 1;
      2'd3:    return c >> 2;
      default: return c;
    endcase
  endfunction

  assign px_r = odd_q ? shade(rd_q[17:12], scanlines) : rd_q[17:12];
  assign px_g = odd_q ? shade(rd_q[11:6], scanlines) : rd_q[11:6];
  assign px_b = odd_q ? shade(rd_q[5:0], scanlines) : rd_q[5:0];
`else
  logic unused_cfg;
  assign unused_cfg = ^{scanlines, odd_q};
  assign px_r = rd_q[17:12];
  assign px_g = rd_q[11:6];
  assign px_b = rd_q[5:0];
`endif

  logic [5:0] r_q, g_q, b_q;
  logic       hso_q, vso_q;
  logic       active;

  assign active = (st_q == EVEN) || (st_q == ODD);

  // Stage 1 (act/odd/hsl) lines up with the registered buffer read;
  // stage 2 is the output register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      st_q <= IDLE;
      oc_q <= '0;
      act_q <= 1'b0;
      odd_q <= 1'b0;
      hsl_q <= 1'b0;
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
      hso_q <= 1'b1;
      vso_q <= 1'b1;
    end else begin
      act_q <= active;
      odd_q <= (st_q == ODD);
      hsl_q <= active && (oc_q[AW:1] < hs_width_q);
      if (line_go) begin
        st_q <= EVEN;
        oc_q <= '0;
      end else begin
        oc_q <= oc_q + (AW + 1)'(1);
        unique case (st_q)
          EVEN: if (oc_q == oc_last) begin
            st_q <= ODD;
            oc_q <= '0;
          end
          ODD: if (oc_q == oc_last) st_q <= HOLD;
          default: ;
        endcase
      end
      if (bypass) begin
        r_q <= R_in;
        g_q <= G_in;
        b_q <= B_in;
        hso_q <= HSync;
        vso_q <= VSync;
      end else begin
        r_q <= act_q ? px_r : '0;
        g_q <= act_q ? px_g : '0;
        b_q <= act_q ? px_b : '0;
        hso_q <= ~hsl_q;
        vso_q <= vs_line_q;
      end
    end
  end

  assign R_out = r_q;
  assign G_out = g_q;
  assign B_out = b_q;
  assign HSync_out = hso_q;
  assign VSync_out = vso_q;

endmodule

// File: tb/tb_scandoubler.sv
// tb_scandoubler: directed bench for the scandoubler line doubler.
// Drives 4:1 ce_pix lines and checks logged 31 kHz output against constants.
module tb_scandoubler;

  localparam int MAXC = 65536;

  logic       clk = 0;
  logic       reset = 1;
  logic       ce_pix = 0;
  logic       bypass = 0;
  logic [1:0] scanlines = 0;
  logic [5:0] R_in = 0, G_in = 0, B_in = 0;
  logic       HSync = 1, VSync = 1;
  logic [5:0] R_out, G_out, B_out;
  logic       HSync_out, VSync_out;

  scandoubler #(.ADDR_WIDTH(10)) dut (
    .clk_sys(clk),
    .reset(reset),
    .ce_pix(ce_pix),
    .bypass(bypass),
    .scanlines(scanlines),
    .R_in(R_in),
    .G_in(G_in),
    .B_in(B_in),
    .HSync(HSync),
    .VSync(VSync),
    .R_out(R_out),
    .G_out(G_out),
    .B_out(B_out),
    .HSync_out(HSync_out),
    .VSync_out(VSync_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int total = 0;
  int passed = 0;

  logic [5:0] r_log [MAXC];
  logic [5:0] g_log [MAXC];
  logic [5:0] b_log [MAXC];
  logic       h_log [MAXC];
  int falls[$];
  int lows[$];
  int fall_t = 0;
  logic hs_prev = 1;

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      r_log[cyc] = R_out;
      g_log[cyc] = G_out;
      b_log[cyc] = B_out;
      h_log[cyc] = HSync_out;
    end
    if (hs_prev && !HSync_out) begin
      falls.push_back(cyc);
      fall_t = cyc;
    end
    if (!hs_prev && HSync_out) lows.push_back(cyc - fall_t);
    hs_prev = HSync_out;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Pixel p of a line: R = p[5:0] (or constant rc), G = p[11:6],
  // B = p[5:0]^0x2A. HSync low for p < hsw. e = cycle of pixel 0.
  task automatic drive_line(input int n, input int hsw, input int rc,
                            input logic vs, output int e);
    for (int p = 0; p < n; p++) begin
      @(posedge clk); #1;
      if (p == 0) e = cyc;
      ce_pix = 1;
      HSync = (p < hsw) ? 1'b0 : 1'b1;
      VSync = vs;
      R_in = (rc < 0) ? 6'(p) : 6'(rc);
      G_in = 6'(p >> 6);
      B_in = 6'(p) ^ 6'h2A;
      @(posedge clk); #1;
      ce_pix = 0;
      repeat (2) @(posedge clk);
    end
  endtask

  task automatic test_reset();
    int t, e3, e4;
    repeat (3) @(posedge clk); #1;
    total++;
    if ({R_out, G_out, B_out, HSync_out, VSync_out} !== {18'd0, 2'b11})
      $display("FAIL reset_state got=%h want=%h",
               {R_out, G_out, B_out, HSync_out, VSync_out}, {18'd0, 2'b11});
    else passed++;
    reset = 0;
    drive_line(20, 0, -1, 0, t);
    drive_line(400, 30, -1, 0, t);
    drive_line(400, 30, -1, 0, t);
    fork
      drive_line(400, 30, -1, 0, t);
      begin
        repeat (20) @(posedge clk); #1;
        total++;
        if ({HSync_out, VSync_out} !== 2'b00)
          $display("FAIL pre_reset_syncs got=%b want=00",
                   {HSync_out, VSync_out});
        else passed++;
        reset = 1;
        #1;
        total++;
        if ({R_out, G_out, B_out, HSync_out, VSync_out} !== {18'd0, 2'b11})
          $display("FAIL midframe_reset got=%h want=%h",
                   {R_out, G_out, B_out, HSync_out, VSync_out},
                   {18'd0, 2'b11});
        else passed++;
        repeat (3) @(posedge clk); #1;
        reset = 0;
        falls.delete();
        lows.delete();
      end
    join
    drive_line(400, 30, -1, 0, e3);
    drive_line(400, 30, -1, 0, e4);
    total++;
    t = (falls.size() > 0) ? falls[0] : -1;
    if (t !== e4 + 3)
      $display("FAIL first_fall_after_reset got=%0d want=%0d", t, e4 + 3);
    else passed++;
  endtask

  task automatic test_doubling();
    int ea, eb, g;
    int exp_f[4];
    drive_line(400, 30, -1, 1, ea);
    falls.delete();
    lows.delete();
    drive_line(400, 30, -1, 1, ea);
    drive_line(400, 30, -1, 1, eb);
    exp_f = '{ea + 3, ea + 803, eb + 3, eb + 803};
    for (int i = 0; i < 4; i++) begin
      total++;
      g = (i < falls.size()) ? falls[i] : -1;
      if (g !== exp_f[i])
        $display("FAIL dbl_fall%0d got=%0d want=%0d", i, g, exp_f[i]);
      else passed++;
      total++;
      g = (i < lows.size()) ? lows[i] : -1;
      if (g !== 60)
        $display("FAIL dbl_low%0d got=%0d want=60", i, g);
      else passed++;
    end
    total++;
    if ({r_log[ea + 22], r_log[ea + 23], r_log[ea + 24], r_log[ea + 25]}
        !== {6'd9, 6'd10, 6'd10, 6'd11})
      $display("FAIL dbl_pix10 got=%0d,%0d,%0d,%0d want=9,10,10,11",
               r_log[ea + 22], r_log[ea + 23], r_log[ea + 24],
               r_log[ea + 25]);
    else passed++;
    total++;
    if (b_log[ea + 23] !== 6'd32)
      $display("FAIL dbl_blue10 got=%0d want=32", b_log[ea + 23]);
    else passed++;
    total++;
    if (r_log[ea + 823] !== 6'd10)
      $display("FAIL dbl_odd_pix10 got=%0d want=10", r_log[ea + 823]);
    else passed++;
  endtask

  task automatic test_scanlines();
    int e, exp_odd;
    int lv[4] = '{2, 1, 3, 0};
    scanlines = 0;
    drive_line(400, 30, 40, 1, e);
    for (int i = 0; i < 4; i++) begin
      scanlines = 2'(lv[i]);
`ifdef SCANDOUBLER_SCANLINES_EN
      case (lv[i])
        1: exp_odd = 30;
        2: exp_odd = 20;
        3: exp_odd = 10;
        default: exp_odd = 40;
      endcase
`else
      exp_odd = 40;
`endif
      drive_line(400, 30, 40, 1, e);
      total++;
      if (r_log[e + 23] !== 6'd40)
        $display("FAIL scan%0d_even got=%0d want=40", lv[i], r_log[e + 23]);
      else passed++;
      total++;
      if (r_log[e + 823] !== 6'(exp_odd))
        $display("FAIL scan%0d_odd got=%0d want=%0d", lv[i],
                 r_log[e + 823], exp_odd);
      else passed++;
    end
    scanlines = 0;
  endtask

  task automatic test_bypass();
    logic [19:0] v, o;
    int e, t;
    bypass = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      v = 20'($urandom);
      {R_in, G_in, B_in, HSync, VSync} = v;
      ce_pix = (i % 4 == 0);
      @(posedge clk); #1;
      o = {R_out, G_out, B_out, HSync_out, VSync_out};
      total++;
      if (o !== v)
        $display("FAIL bypass%0d got=%h want=%h", i, o, v);
      else passed++;
    end
    ce_pix = 0;
    HSync = 1;
    bypass = 0;
    drive_line(8, 0, -1, 1, t);
    drive_line(400, 30, -1, 1, t);
    falls.delete();
    drive_line(400, 30, -1, 1, e);
    total++;
    t = (falls.size() > 0) ? falls[0] : -1;
    if (t !== e + 3 || r_log[e + 23] !== 6'd10)
      $display("FAIL bypass_exit got=%0d/%0d want=%0d/10",
               t, r_log[e + 23], e + 3);
    else passed++;
  endtask

  task automatic test_overlong();
    int ea, eb, g;
    drive_line(1100, 30, -1, 1, ea);
    falls.delete();
    drive_line(1100, 30, -1, 1, eb);
    total++;
    g = (falls.size() > 1) ? falls[1] : -1;
    if (falls.size() !== 2 || falls[0] !== eb + 3 || g !== eb + 2049)
      $display("FAIL long_falls got=%0d,n=%0d want=%0d,n=2",
               g, falls.size(), eb + 2049);
    else passed++;
    total++;
    if ({r_log[eb + 3], g_log[eb + 3]} !== 12'd0)
      $display("FAIL long_pix0 got=%0d,%0d want=0,0",
               r_log[eb + 3], g_log[eb + 3]);
    else passed++;
    total++;
    if ({r_log[eb + 2047], g_log[eb + 2047]} !== {6'd62, 6'd15})
      $display("FAIL long_pix1022 got=%0d,%0d want=62,15",
               r_log[eb + 2047], g_log[eb + 2047]);
    else passed++;
    total++;
    if (r_log[eb + 4093] !== 6'd62)
      $display("FAIL long_odd1022 got=%0d want=62", r_log[eb + 4093]);
    else passed++;
    total++;
    if ({r_log[eb + 4300], g_log[eb + 4300], b_log[eb + 4300],
         h_log[eb + 4300]} !== {18'd0, 1'b1})
      $display("FAIL long_hold got=%h want=%h",
               {r_log[eb + 4300], g_log[eb + 4300], b_log[eb + 4300],
                h_log[eb + 4300]}, {18'd0, 1'b1});
    else passed++;
  endtask

  task automatic test_shorten();
    int e1, e2, e3, g;
    int exp_f[4];
    drive_line(400, 30, -1, 1, e1);
    falls.delete();
    lows.delete();
    drive_line(300, 30, -1, 1, e2);
    drive_line(300, 30, -1, 1, e3);
    exp_f = '{e2 + 3, e2 + 803, e3 + 3, e3 + 603};
    total++;
    if (falls.size() !== 4)
      $display("FAIL short_nfalls got=%0d want=4", falls.size());
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      g = (i < falls.size()) ? falls[i] : -1;
      if (g !== exp_f[i])
        $display("FAIL short_fall%0d got=%0d want=%0d", i, g, exp_f[i]);
      else passed++;
      total++;
      g = (i < lows.size()) ? lows[i] : -1;
      if (g !== 60)
        $display("FAIL short_low%0d got=%0d want=60", i, g);
      else passed++;
    end
    total++;
    if ({r_log[e3 + 2], r_log[e3 + 3]} !== {6'd7, 6'd0})
      $display("FAIL short_cut got=%0d,%0d want=7,0",
               r_log[e3 + 2], r_log[e3 + 3]);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_doubling();
    test_scanlines();
    test_bypass();
    test_overlong();
    test_shorten();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
